// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART TX definitions: FSM state encoding
// and the output multiplexer select codes.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  // Mux select driven while in a given state.
  function automatic logic [1:0] sel_of(
    input state_e s
  );
    logic [1:0] sel;
    sel = SEL_STOP;
    unique case (s)
      ST_START:  sel = SEL_START;
      ST_DATA:   sel = SEL_DATA;
      ST_PARITY: sel = SEL_PAR;
      default:   sel = SEL_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register plus bit counter; LSB first.
// Ports: clk, rst_n, load, shift_en, data_in, ser_out, done.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ser_out,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] sr;
  logic [CNT_WIDTH-1:0]  cnt;

  assign done    = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));
  // sr[0] is a flop, so the current bit is already registered.
  assign ser_out = sr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data_in;
      cnt <= '0;
    end else if (shift_en) begin
      sr <= {1'b0, sr[DATA_WIDTH-1:1]};
      // Saturate at the last index; never wraps.
      if (!done) cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX control: frames start/data/parity/stop.
// In: CLK RST P_DATA Data_Valid PAR_EN PAR_TYP; Out: Selection_Bits Ser_Data Par_Bit Busy.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            Selection_Bits,
  output logic                  Ser_Data,
  output logic                  Par_Bit,
  output logic                  Busy
);

  state_e state, state_nxt;
  logic   accept;
  logic   par_en_q;
  logic   done;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (Data_Valid) begin
          accept    = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START:  state_nxt = ST_DATA;
      ST_DATA: begin
        if (done)
          state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= ST_IDLE;
      Selection_Bits <= SEL_STOP;
      Busy           <= 1'b0;
      Par_Bit        <= 1'b0;
      par_en_q       <= 1'b0;
    end else begin
      state          <= state_nxt;
      Selection_Bits <= sel_of(state_nxt);
      Busy           <= (state_nxt != ST_IDLE);
      if (accept) begin
        Par_Bit  <= ^P_DATA ^ PAR_TYP;
        par_en_q <= PAR_EN;
      end
    end
  end

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_ser (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (accept),
    .shift_en (state == ST_DATA),
    .data_in  (P_DATA),
    .ser_out  (Ser_Data),
    .done     (done)
  );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl against a
// per-cycle frame model built from the frame rules.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] Selection_Bits;
  logic       Ser_Data;
  logic       Par_Bit;
  logic       Busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .P_DATA         (P_DATA),
    .Data_Valid     (Data_Valid),
    .PAR_EN         (PAR_EN),
    .PAR_TYP        (PAR_TYP),
    .Selection_Bits (Selection_Bits),
    .Ser_Data       (Ser_Data),
    .Par_Bit        (Par_Bit),
    .Busy           (Busy)
  );

  // One expected line-cycle: select, busy, optional
  // data bit and optional parity-bit expectation.
  typedef struct packed {
    logic [1:0] sel;
    logic       busy;
    logic       cs;
    logic       ser;
    logic       cp;
    logic       par;
  } exp_t;

  exp_t q[$];

  function automatic logic par_of(input logic [7:0] d,
                                  input logic pt);
    return (($countones(d) % 2) != 0) ^ pt;
  endfunction

  function automatic void push_frame(input logic [7:0] d,
                                     input logic pe,
                                     input logic pt);
    logic p;
    p = par_of(d, pt);
    q.push_back('{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, p});
    for (int i = 0; i < 8; i++)
      q.push_back('{2'b10, 1'b1, 1'b1, d[i], 1'b1, p});
    if (pe)
      q.push_back('{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, p});
    q.push_back('{2'b01, 1'b1, 1'b0, 1'b0, 1'b1, p});
  endfunction

  function automatic void push_idle(input logic p);
    q.push_back('{2'b01, 1'b0, 1'b0, 1'b0, 1'b1, p});
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    P_DATA = 8'hA5; Data_Valid = 0;
    PAR_EN = 0; PAR_TYP = 0;
    repeat (2) @(negedge CLK);
    n_chk += 4;
    if (Selection_Bits !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_sel got %b exp 01", Selection_Bits);
    end
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy got %b exp 0", Busy);
    end
    if (Ser_Data !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ser got %b exp 0", Ser_Data);
    end
    if (Par_Bit !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_par got %b exp 0", Par_Bit);
    end
    RST = 1'b1;
    @(negedge CLK);
    // Start 0xA5 and abort it mid-DATA.
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    n_chk++;
    if (Selection_Bits !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_pre_sel got %b exp 10",
               Selection_Bits);
    end
    #2 RST = 1'b0;
    #1;
    n_chk += 2;
    if (Selection_Bits !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_async_sel got %b exp 01",
               Selection_Bits);
    end
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async_busy got %b exp 0", Busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      n_chk += 3;
      if (Selection_Bits !== 2'b01) begin
        n_fail++;
        $display("FAIL rst_idle_sel c%0d got %b exp 01",
                 k, Selection_Bits);
      end
      if (Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_idle_busy c%0d got %b exp 0",
                 k, Busy);
      end
      if (Par_Bit !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_idle_par c%0d got %b exp 0",
                 k, Par_Bit);
      end
    end
  endtask

  task automatic test_frame(input logic [7:0] d,
                            input logic pe,
                            input logic pt);
    exp_t e;
    q.delete();
    push_frame(d, pe, pt);
    push_idle(par_of(d, pt));
    push_idle(par_of(d, pt));
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
    Data_Valid = 1'b1;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      e = q[k];
      n_chk += 2;
      if (Selection_Bits !== e.sel) begin
        n_fail++;
        $display("FAIL frm_sel d=%h c%0d got %b exp %b",
                 d, k, Selection_Bits, e.sel);
      end
      if (Busy !== e.busy) begin
        n_fail++;
        $display("FAIL frm_busy d=%h c%0d got %b exp %b",
                 d, k, Busy, e.busy);
      end
      if (e.cs) begin
        n_chk++;
        if (Ser_Data !== e.ser) begin
          n_fail++;
          $display("FAIL frm_ser d=%h c%0d got %b exp %b",
                   d, k, Ser_Data, e.ser);
        end
      end
      if (e.cp) begin
        n_chk++;
        if (Par_Bit !== e.par) begin
          n_fail++;
          $display("FAIL frm_par d=%h c%0d got %b exp %b",
                   d, k, Par_Bit, e.par);
        end
      end
    end
  endtask

  task automatic test_input_stability();
    exp_t e;
    q.delete();
    push_frame(8'h3C, 1'b1, 1'b0);
    push_idle(par_of(8'h3C, 1'b0));
    push_idle(par_of(8'h3C, 1'b0));
    push_idle(par_of(8'h3C, 1'b0));
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    Data_Valid = 1'b1;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge CLK);
      e = q[k];
      if (!e.busy) begin
        Data_Valid = 1'b0;
      end else if (e.sel == 2'b01) begin
        Data_Valid = 1'b1;
      end else begin
        P_DATA = 8'hFF;
        PAR_EN = ~PAR_EN;
        PAR_TYP = 1'($urandom_range(1));
        Data_Valid = 1'($urandom_range(1));
      end
      n_chk += 2;
      if (Selection_Bits !== e.sel) begin
        n_fail++;
        $display("FAIL stab_sel c%0d got %b exp %b",
                 k, Selection_Bits, e.sel);
      end
      if (Busy !== e.busy) begin
        n_fail++;
        $display("FAIL stab_busy c%0d got %b exp %b",
                 k, Busy, e.busy);
      end
      if (e.cs) begin
        n_chk++;
        if (Ser_Data !== e.ser) begin
          n_fail++;
          $display("FAIL stab_ser c%0d got %b exp %b",
                   k, Ser_Data, e.ser);
        end
      end
      if (e.cp) begin
        n_chk++;
        if (Par_Bit !== e.par) begin
          n_fail++;
          $display("FAIL stab_par c%0d got %b exp %b",
                   k, Par_Bit, e.par);
        end
      end
    end
    PAR_EN = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    q.delete();
    push_frame(8'h00, 1'b0, 1'b0);
    push_idle(par_of(8'h00, 1'b0));
    push_frame(8'hFF, 1'b0, 1'b0);
    push_idle(par_of(8'hFF, 1'b0));
    push_idle(par_of(8'hFF, 1'b0));
    @(negedge CLK);
    P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    Data_Valid = 1'b1;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge CLK);
      e = q[k];
      if (k == 0) P_DATA = 8'hFF;
      // Drop the request once frame 2 has started.
      if (k == 11) Data_Valid = 1'b0;
      n_chk += 2;
      if (Selection_Bits !== e.sel) begin
        n_fail++;
        $display("FAIL b2b_sel c%0d got %b exp %b",
                 k, Selection_Bits, e.sel);
      end
      if (Busy !== e.busy) begin
        n_fail++;
        $display("FAIL b2b_busy c%0d got %b exp %b",
                 k, Busy, e.busy);
      end
      if (e.cs) begin
        n_chk++;
        if (Ser_Data !== e.ser) begin
          n_fail++;
          $display("FAIL b2b_ser c%0d got %b exp %b",
                   k, Ser_Data, e.ser);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, 1'b0, 1'b0);
    test_frame(8'hA5, 1'b1, 1'b0);
    test_frame(8'hA5, 1'b1, 1'b1);
    test_frame(8'h01, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++)
      test_frame(8'($urandom), 1'($urandom_range(1)),
                 1'($urandom_range(1)));
    test_input_stability();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
